// File: rtl/cordic_seq_ctrl.sv
// Sequencing controller for the iterative CORDIC sin/cos datapath (load, ITER micro-rotations, quadrant fix-up).
// Latency: start-sampling edge to ready_cordic edge = 2 + ITER*(ADD_LAT+1) cycles (74 with defaults).
// Backpressure: starts are taken only in IDLE; with CORDIC_CTRL_ACK_EN the result is held until ack_cordic.
//
// Optional feature macro: CORDIC_CTRL_ACK_EN (hold ready_cordic until ack_cordic; default is a 1-cycle pulse).
//
// Ports:
//   clk, rst               clock, synchronous active-low reset
//   beg_fsm_cordic         start request (IDLE only)
//   ack_cordic             result consumed (ack build only)
//   operation              0 = cos, 1 = sin, latched at start
//   shift_region_flag      argument-reduction region, latched at start
//   z_sign_i               Z sign, captured into dir_o on issue cycles
//   load_init, sel_mux_1   initial load strobe / feedback path select
//   addsub_start, dir_o    micro-rotation launch pulse / rotation direction
//   enab_iter, cont_iter   adder-result capture pulse / iteration index
//   enab_out, sel_mux_3,   output register load / X-Y select /
//   inv_sign               result sign inversion
//   busy, ready_cordic     operation in flight / result valid
module cordic_seq_ctrl #(
    parameter int W       = 32,
    parameter int ITER    = 24,
    parameter int CNT_W   = 5,
    parameter int ADD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beg_fsm_cordic,
    input  logic             ack_cordic,
    input  logic             operation,
    input  logic [1:0]       shift_region_flag,
    input  logic             z_sign_i,
    output logic             load_init,
    output logic             sel_mux_1,
    output logic             addsub_start,
    output logic             dir_o,
    output logic             enab_iter,
    output logic [CNT_W-1:0] cont_iter,
    output logic             enab_out,
    output logic             sel_mux_3,
    output logic             inv_sign,
    output logic             busy,
    output logic             ready_cordic
);

    localparam int S_W = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);
    localparam logic [S_W-1:0]   SUB_LAST  = S_W'(ADD_LAT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_POST,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             op_q;
    logic [1:0]       region_q;
    logic [CNT_W-1:0] cnt_q;
    logic [S_W-1:0]   sub_q;
    logic             dir_q;
    logic             sel3_q;
    logic             inv_q;

    logic             accept;
    logic             issue;
    logic             retire;
    logic             last;
    logic             sel_map;
    logic             inv_map;

    // W only documents the datapath width; ack_cordic is dead in the pulse build.
    logic [W-1:0]     unused_w;
    assign unused_w = {W{ack_cordic}};

    assign accept = (state_q == ST_IDLE) && beg_fsm_cordic;
    assign issue  = (state_q == ST_ITER) && (sub_q == '0);
    assign retire = (state_q == ST_ITER) && (sub_q == SUB_LAST);
    assign last   = retire && (cnt_q == LAST_ITER);

    // Quadrant correction: which of X/Y carries the answer and whether its sign flips,
    // indexed by {operation, region}.
    always_comb begin
        sel_map = 1'b0;
        inv_map = 1'b0;
        case ({op_q, region_q})
            3'b000: begin sel_map = 1'b0; inv_map = 1'b0; end
            3'b001: begin sel_map = 1'b1; inv_map = 1'b1; end
            3'b010: begin sel_map = 1'b1; inv_map = 1'b0; end
            3'b011: begin sel_map = 1'b0; inv_map = 1'b0; end
            3'b100: begin sel_map = 1'b1; inv_map = 1'b0; end
            3'b101: begin sel_map = 1'b0; inv_map = 1'b0; end
            3'b110: begin sel_map = 1'b0; inv_map = 1'b1; end
            3'b111: begin sel_map = 1'b1; inv_map = 1'b0; end
            default: begin sel_map = 1'b0; inv_map = 1'b0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_init    = 1'b0;
        sel_mux_1    = 1'b0;
        addsub_start = 1'b0;
        enab_iter    = 1'b0;
        enab_out     = 1'b0;
        busy         = 1'b0;
        ready_cordic = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (beg_fsm_cordic) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_init = 1'b1;
                busy      = 1'b1;
                state_d   = ST_ITER;
            end
            ST_ITER: begin
                busy         = 1'b1;
                // First rotation still works on the freshly loaded initial values.
                sel_mux_1    = (cnt_q != '0);
                addsub_start = issue;
                enab_iter    = retire;
                if (last) begin
                    state_d = ST_POST;
                end
            end
            ST_POST: begin
                busy     = 1'b1;
                enab_out = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                ready_cordic = 1'b1;
`ifdef CORDIC_CTRL_ACK_EN
                if (ack_cordic) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q     <= 1'b0;
            region_q <= 2'b00;
            cnt_q    <= '0;
            sub_q    <= '0;
            dir_q    <= 1'b0;
            sel3_q   <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= operation;
                region_q <= shift_region_flag;
                cnt_q    <= '0;
                sub_q    <= '0;
                sel3_q   <= 1'b0;
                inv_q    <= 1'b0;
            end
            if (issue) begin
                dir_q <= z_sign_i;
            end
            if (retire) begin
                sub_q <= '0;
                // Counter parks on the last index rather than wrapping.
                if (!last) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else if (state_q == ST_ITER) begin
                sub_q <= sub_q + S_W'(1);
            end
            // Captured on entry to POST so the values are already valid while enab_out is high.
            if (last) begin
                sel3_q <= sel_map;
                inv_q  <= inv_map;
            end
        end
    end

    assign cont_iter = cnt_q;
    assign dir_o     = dir_q;
    assign sel_mux_3 = sel3_q;
    assign inv_sign  = inv_q;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
module tb_cordic_seq_ctrl;

    localparam int ITER    = 24;
    localparam int CNT_W   = 5;
    localparam int ADD_LAT = 2;
    localparam int LAT     = 2 + ITER * (ADD_LAT + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             beg_fsm_cordic;
    logic             ack_cordic;
    logic             operation;
    logic [1:0]       shift_region_flag;
    logic             z_sign_i;
    logic             load_init;
    logic             sel_mux_1;
    logic             addsub_start;
    logic             dir_o;
    logic             enab_iter;
    logic [CNT_W-1:0] cont_iter;
    logic             enab_out;
    logic             sel_mux_3;
    logic             inv_sign;
    logic             busy;
    logic             ready_cordic;

    cordic_seq_ctrl #(
        .W      (32),
        .ITER   (ITER),
        .CNT_W  (CNT_W),
        .ADD_LAT(ADD_LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .beg_fsm_cordic   (beg_fsm_cordic),
        .ack_cordic       (ack_cordic),
        .operation        (operation),
        .shift_region_flag(shift_region_flag),
        .z_sign_i         (z_sign_i),
        .load_init        (load_init),
        .sel_mux_1        (sel_mux_1),
        .addsub_start     (addsub_start),
        .dir_o            (dir_o),
        .enab_iter        (enab_iter),
        .cont_iter        (cont_iter),
        .enab_out         (enab_out),
        .sel_mux_3        (sel_mux_3),
        .inv_sign         (inv_sign),
        .busy             (busy),
        .ready_cordic     (ready_cordic)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int              start_cyc;
        bit              sel;
        bit              inv;
        logic [ITER-1:0] zpat;
    } exp_t;

    exp_t q[$];

    // Quadrant correction model: cos wants X when the region count is even-parity,
    // sin wants the other register; only cos/region1 and sin/region2 come out negated.
    function automatic bit ref_sel(input bit op, input logic [1:0] rg);
        bit odd;
        odd = rg[0] ^ rg[1];
        return op ? !odd : odd;
    endfunction

    function automatic bit ref_inv(input bit op, input logic [1:0] rg);
        return op ? (rg == 2'd2) : (rg == 2'd1);
    endfunction

    function automatic int all_outs();
        logic [CNT_W+9:0] v;
        v = {load_init, sel_mux_1, addsub_start, dir_o, enab_iter, cont_iter,
             enab_out, sel_mux_3, inv_sign, busy, ready_cordic};
        return int'(v);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int              n_iter, n_issue, dir_idx;
    bit              dir_pend, rdy_prev;
    logic [ITER-1:0] cur_z;
    exp_t            mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            n_iter   = 0;
            n_issue  = 0;
            dir_pend = 0;
            rdy_prev = 0;
        end else begin
            if (dir_pend) begin
                dir_pend = 0;
                if (q.size() > 0) begin
                    cur_z = q[0].zpat;
                    chk("dir_o", dir_o, cur_z[dir_idx]);
                end
            end
            if (load_init) begin
                n_iter  = 0;
                n_issue = 0;
            end
            if (addsub_start) begin
                chk("sel_mux_1", sel_mux_1, (n_issue != 0));
                dir_idx  = n_issue;
                dir_pend = 1;
                n_issue++;
            end
            if (enab_iter) begin
                chk("cont_iter", cont_iter, n_iter);
                n_iter++;
            end
            if (enab_out && q.size() > 0) begin
                chk("post_sel_mux_3", sel_mux_3, q[0].sel);
                chk("post_inv_sign", inv_sign, q[0].inv);
                chk("enab_iter_count", n_iter, ITER);
                chk("addsub_count", n_issue, ITER);
            end
            if (ready_cordic && !rdy_prev) begin
                chk("ready_expected", (q.size() > 0), 1);
                if (q.size() > 0) begin
                    mon_e = q.pop_front();
                    chk("latency", cyc - mon_e.start_cyc, LAT);
                    chk("done_sel_mux_3", sel_mux_3, mon_e.sel);
                    chk("done_inv_sign", inv_sign, mon_e.inv);
                    chk("done_busy", busy, 0);
                end
            end
`ifndef CORDIC_CTRL_ACK_EN
            if (ready_cordic) chk("ready_pulse_width", rdy_prev, 0);
`endif
            rdy_prev = ready_cordic;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input bit op, input logic [1:0] rg, input logic [ITER-1:0] zp,
                          input int gap, input bit stray);
        exp_t e;
        beg_fsm_cordic    = 1'b1;
        operation         = op;
        shift_region_flag = rg;
        tick();
        beg_fsm_cordic    = 1'b0;
        e.start_cyc = cyc;
        e.sel       = ref_sel(op, rg);
        e.inv       = ref_inv(op, rg);
        e.zpat      = zp;
        q.push_back(e);
        operation         = 1'($urandom);
        shift_region_flag = 2'($urandom);
        tick();
        for (int k = 0; k < ITER; k++) begin
            for (int s = 0; s <= ADD_LAT; s++) begin
                z_sign_i          = (s == 0) ? zp[k] : ~zp[k];
                beg_fsm_cordic    = stray && (k == 5) && (s == 1);
                operation         = 1'($urandom);
                shift_region_flag = 2'($urandom);
                tick();
            end
        end
        beg_fsm_cordic = 1'b0;
        z_sign_i       = 1'b0;
        tick();
`ifdef CORDIC_CTRL_ACK_EN
        for (int i = 0; i < 5; i++) begin
            chk("ready_held", ready_cordic, 1);
            tick();
        end
        ack_cordic = 1'b1;
        tick();
        ack_cordic = 1'b0;
        chk("idle_after_ack", {busy, ready_cordic}, 0);
`else
        beg_fsm_cordic = stray;
        tick();
        beg_fsm_cordic = 1'b0;
        chk("idle_after_done", {busy, ready_cordic, load_init}, 0);
`endif
        repeat (gap) tick();
    endtask

    initial begin
        rst               = 1'b0;
        beg_fsm_cordic    = 1'b0;
        ack_cordic        = 1'b0;
        operation         = 1'b0;
        shift_region_flag = 2'b00;
        z_sign_i          = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            z_sign_i = 1'($urandom);
            chk("idle_outputs", all_outs(), 0);
            tick();
        end
        z_sign_i = 1'b0;

        // Cosine, region 0, direction alternating 1,0,1,0...
        run_op(1'b0, 2'b00, 24'h555555, 0, 1'b0);

        for (int c = 0; c < 8; c++) begin
            run_op(c[2], c[1:0], ITER'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        // Abort at iteration 10.
        beg_fsm_cordic    = 1'b1;
        operation         = 1'b1;
        shift_region_flag = 2'b10;
        tick();
        beg_fsm_cordic = 1'b0;
        tick();
        for (int i = 0; i < 10 * (ADD_LAT + 1); i++) begin
            z_sign_i = 1'($urandom);
            tick();
        end
        chk("busy_before_abort", busy, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("outputs_after_abort", all_outs(), 0);
        tick();
        chk("idle_after_abort", all_outs(), 0);

        run_op(1'b0, 2'b01, ITER'($urandom), 1, 1'b1);

        for (int i = 0; i < 5; i++) begin
            run_op(1'($urandom), 2'($urandom), ITER'($urandom), $urandom_range(0, 4), 1'($urandom));
        end

        repeat (5) tick();
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cordic_seq_ctrl.md
# cordic_seq_ctrl

Sequencing controller for the iterative CORDIC sine/cosine datapath. Accepts a start request, drives the load, iterate and output-register enables of the shared X/Y/Z add/subtract datapath for a fixed number of micro-rotations, and counts iterations. At the end it applies quadrant correction: the output mux select and the result sign inversion, derived from the requested operation and the argument-reduction region. It sits between the FPU interface handshake and the CORDIC datapath registers.

## Interface
Parameters:
- `W`, 32: datapath word width; informational only, no port uses it.
- `ITER`, 24: number of CORDIC micro-rotations.
- `CNT_W`, 5: width of the iteration counter; must satisfy 2^CNT_W > ITER.
- `ADD_LAT`, 2: add/subtract unit latency in cycles; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `beg_fsm_cordic`  in  1  start request; sampled only in IDLE.
- `ack_cordic`  in  1  result consumed (used only with `CORDIC_CTRL_ACK_EN`).
- `operation`  in  1  0 = cosine, 1 = sine; latched at start.
- `shift_region_flag`  in  2  argument-reduction region; latched at start.
- `z_sign_i`  in  1  sign bit of the Z register; sampled on issue cycles.
- `load_init`  out  1  load initial X/Y/Z values.
- `sel_mux_1`  out  1  0 = initial-value path, 1 = feedback path.
- `addsub_start`  out  1  one-cycle pulse to launch a micro-rotation.
- `dir_o`  out  1  rotation direction for the current iteration.
- `enab_iter`  out  1  one-cycle pulse to capture adder results.
- `cont_iter`  out  CNT_W  current iteration index (shift amount).
- `enab_out`  out  1  load the output register.
- `sel_mux_3`  out  1  X/Y result select for the output register.
- `inv_sign`  out  1  invert the sign bit of the result.
- `busy`  out  1  high in every state other than IDLE and DONE.
- `ready_cordic`  out  1  result valid.

## Operation
- Reset (`rst` = 0 at a clock edge): state goes to IDLE.
  - All outputs are 0, `cont_iter` is 0, and the latched op/region are 00.
  - Reset overrides everything, including in mid-operation.
- IDLE:
  - When `beg_fsm_cordic` = 1, latch `operation` and `shift_region_flag`, then go to LOAD.
- LOAD (1 cycle):
  - `load_init` = 1, `sel_mux_1` = 0, `cont_iter` = 0, sub-counter = 0.
  - Next state is ITER.
- ITER: one micro-rotation occupies ADD_LAT+1 cycles, tracked by a sub-counter `s` running 0..ADD_LAT.
  - `s` = 0 (issue cycle): `addsub_start` = 1; `dir_o` registers `z_sign_i`.
  - `s` = ADD_LAT: `enab_iter` = 1, then `cont_iter` increments and `s` resets to 0.
  - `sel_mux_1` = 0 while `cont_iter` = 0, and 1 for every later iteration.
  - When `enab_iter` fires with `cont_iter` = ITER-1, go to POST; `cont_iter` does not wrap.
- POST (1 cycle): `enab_out` = 1; drive `sel_mux_3` and `inv_sign` from the latched op/region:
  - cosine: 00 → sel 0, inv 0; 01 → sel 1, inv 1; 10 → sel 1, inv 0; 11 → sel 0, inv 0.
  - sine: 00 → sel 1, inv 0; 01 → sel 0, inv 0; 10 → sel 0, inv 1; 11 → sel 1, inv 0.
  - `sel_mux_3` and `inv_sign` keep these values until the next LOAD.
- DONE: `ready_cordic` = 1. Exit behaviour depends on configuration (see Configuration).
- `beg_fsm_cordic` asserted outside IDLE is ignored and is not queued.
- Changes on `operation` or `shift_region_flag` after the start cycle have no effect on the running operation.

## Timing
- Latency from the edge that samples `beg_fsm_cordic` to the edge that sets `ready_cordic` is 2 + ITER·(ADD_LAT+1) cycles; with defaults this is 74.
- `load_init`, `addsub_start`, `enab_iter` and `enab_out` are single-cycle pulses.
- Exactly ITER `addsub_start` pulses and ITER `enab_iter` pulses occur per operation.
- `dir_o` is stable from the cycle after each issue cycle until the next issue cycle.
- Back-to-back operation: a start request in the cycle DONE returns to IDLE is not seen. The earliest accepted start is in the first IDLE cycle.

## Configuration
- Macro: `CORDIC_CTRL_ACK_EN`.
- Defined: DONE holds `ready_cordic` = 1 until `ack_cordic` = 1, then goes to IDLE on that edge. `ack_cordic` in any other state is ignored.
- Undefined: DONE lasts exactly one cycle, so `ready_cordic` is a one-cycle pulse, and `ack_cordic` is unused. Latency is unchanged.

## Test plan
- Reset then idle: hold `rst` = 0 for 3 cycles, release, keep `beg_fsm_cordic` = 0 for 10 cycles → every output stays 0 and `busy` = 0.
- Single cosine, region 00, default parameters: `ready_cordic` rises 74 cycles after start; 24 `enab_iter` pulses with `cont_iter` counting 0..23; `sel_mux_3` = 0, `inv_sign` = 0.
- All 8 op/region combinations: verify `sel_mux_3`/`inv_sign` against the POST mapping; in particular cos/01 → 1/1 and sin/10 → 0/1.
- Direction tracking: drive `z_sign_i` = 1 on even issue cycles and 0 on odd ones → `dir_o` alternates 1, 0, … after each `addsub_start`.
- Reset mid-operation: assert `rst` = 0 at iteration 10 → the next cycle is IDLE with all outputs 0; a new start then completes in 74 cycles.
- Ack handling with `CORDIC_CTRL_ACK_EN`: hold `ack_cordic` low for 5 cycles → `ready_cordic` stays high; pulse `ack_cordic` → IDLE next cycle. A start pulse during ITER is ignored, with exactly one completion observed.
